// File: rtl/muu_ht_pkg.sv
// Shared constants for the hash-table write stage: opcodes, result codes,
// metadata field offsets and entry sizing.
package muu_ht_pkg;

  localparam logic [3:0] OP_NOP0 = 4'd0;
  localparam logic [3:0] OP_GET  = 4'd1;
  localparam logic [3:0] OP_SET  = 4'd2;
  localparam logic [3:0] OP_DEL  = 4'd3;
  localparam logic [3:0] OP_NOP7 = 4'd7;

  localparam logic [3:0] ST_BYPASS  = 4'd0;
  localparam logic [3:0] ST_HIT     = 4'd1;
  localparam logic [3:0] ST_MISS    = 4'd2;
  localparam logic [3:0] ST_STORED  = 4'd3;
  localparam logic [3:0] ST_FULL    = 4'd4;
  localparam logic [3:0] ST_DELETED = 4'd5;

  localparam int OPCODE_LSB = 88;
  localparam int STATUS_LSB = 92;

  function automatic int entry_width(input int key_width, input int value_width);
    return key_width + value_width;
  endfunction

  // Unknown opcodes carry no bucket responses, so they ride the bypass path.
  function automatic logic is_bypass(input logic [3:0] op);
    if (op == OP_NOP0 || op == OP_NOP7) return 1'b1;
    return !(op == OP_GET || op == OP_SET || op == OP_DEL);
  endfunction

endpackage

// File: rtl/muu_ht_entry_cmp.sv
// Compares one stored bucket key against the lookup key.
module muu_ht_entry_cmp
  import muu_ht_pkg::*;
#(
  parameter int KEY_WIDTH = 128
) (
  input  logic [KEY_WIDTH-1:0] entry_key,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 hit,
  output logic                 empty
);

  // An all-zero lookup key never hits, even against an empty slot.
  assign empty = (entry_key == '0);
  assign hit   = (entry_key == key) && (key != '0);

endmodule

// File: rtl/muu_ht_write.sv
// Write half of the hash-table pipeline: collects both bucket reads, resolves
// GET/SET/DELETE, issues at most one write and returns the annotated record.
module muu_ht_write
  import muu_ht_pkg::*;
#(
  parameter int KEY_WIDTH      = 128,
  parameter int META_WIDTH     = 96,
  parameter int HASHADDR_WIDTH = 64,
  parameter int MEMADDR_WIDTH  = 21,
  parameter int USER_BITS      = 3,
  parameter int VALUE_WIDTH    = 64
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [KEY_WIDTH+META_WIDTH+HASHADDR_WIDTH+USER_BITS-1:0] input_data,
  input  logic                                                  input_valid,
  output logic                                                  input_ready,
  input  logic [KEY_WIDTH+VALUE_WIDTH-1:0]                      rddata_data,
  input  logic                                                  rddata_valid,
  output logic                                                  rddata_ready,
  output logic [31:0]                                           wrcmd_data,
  output logic                                                  wrcmd_valid,
  input  logic                                                  wrcmd_ready,
  output logic [KEY_WIDTH+VALUE_WIDTH-1:0]                      wrdata_data,
  output logic                                                  wrdata_valid,
  input  logic                                                  wrdata_ready,
  output logic [KEY_WIDTH+META_WIDTH+USER_BITS-1:0]             output_data,
  output logic                                                  output_valid,
  input  logic                                                  output_ready
);

  localparam int EW = entry_width(KEY_WIDTH, VALUE_WIDTH);
  localparam int AW = MEMADDR_WIDTH - USER_BITS;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD1, ST_RD2, ST_DECIDE, ST_WRITE, ST_OUTPUT
  } state_t;

  state_t                     state;
  logic [KEY_WIDTH-1:0]       key_q;
  logic [META_WIDTH-1:0]      meta_q;
  logic [USER_BITS-1:0]       user_q;
  logic [MEMADDR_WIDTH-1:0]   addr1_q, addr2_q, wr_addr_q;
  logic [EW-1:0]              ent1_q, ent2_q;

  logic [KEY_WIDTH-1:0]       in_key;
  logic [META_WIDTH-1:0]      in_meta;
  logic [USER_BITS-1:0]       in_user;
  logic [HASHADDR_WIDTH-1:0]  in_hash;
  logic                       unused_hash;

  assign in_key  = input_data[0 +: KEY_WIDTH];
  assign in_meta = input_data[KEY_WIDTH +: META_WIDTH];
  assign in_user = input_data[KEY_WIDTH+META_WIDTH +: USER_BITS];
  assign in_hash = input_data[KEY_WIDTH+META_WIDTH+USER_BITS +: HASHADDR_WIDTH];
  assign unused_hash = ^{in_hash[31:AW], in_hash[63:32+AW]};

  logic hit1, hit2, empty1, empty2;

  muu_ht_entry_cmp #(.KEY_WIDTH(KEY_WIDTH)) u_cmp1 (
    .entry_key (ent1_q[0 +: KEY_WIDTH]),
    .key       (key_q),
    .hit       (hit1),
    .empty     (empty1)
  );

  muu_ht_entry_cmp #(.KEY_WIDTH(KEY_WIDTH)) u_cmp2 (
    .entry_key (ent2_q[0 +: KEY_WIDTH]),
    .key       (key_q),
    .hit       (hit2),
    .empty     (empty2)
  );

  logic [3:0]               opcode;
  logic [3:0]               dec_status;
  logic [VALUE_WIDTH-1:0]   dec_value;
  logic                     dec_write;
  logic [MEMADDR_WIDTH-1:0] dec_addr;
  logic [EW-1:0]            dec_entry;

  assign opcode = meta_q[OPCODE_LSB +: 4];

  always_comb begin
    dec_status = ST_MISS;
    dec_value  = meta_q[0 +: VALUE_WIDTH];
    dec_write  = 1'b0;
    dec_addr   = addr1_q;
    dec_entry  = '0;
    case (opcode)
      OP_GET: begin
        if (hit1) begin
          dec_status = ST_HIT;
          dec_value  = ent1_q[KEY_WIDTH +: VALUE_WIDTH];
        end else if (hit2) begin
          dec_status = ST_HIT;
          dec_value  = ent2_q[KEY_WIDTH +: VALUE_WIDTH];
        end
      end
      OP_SET: begin
        dec_status = ST_STORED;
        dec_entry  = {meta_q[0 +: VALUE_WIDTH], key_q};
        dec_write  = 1'b1;
        // Overwrite an existing copy before claiming a free slot.
        if (hit1)        dec_addr = addr1_q;
        else if (hit2)   dec_addr = addr2_q;
        else if (empty1) dec_addr = addr1_q;
        else if (empty2) dec_addr = addr2_q;
        else begin
          dec_status = ST_FULL;
          dec_write  = 1'b0;
        end
      end
      OP_DEL: begin
        if (hit1 || hit2) begin
          dec_status = ST_DELETED;
          dec_write  = 1'b1;
          dec_addr   = hit1 ? addr1_q : addr2_q;
        end
      end
      default: dec_status = ST_BYPASS;
    endcase
  end

  assign wrcmd_data = {{(32-MEMADDR_WIDTH){1'b0}}, wr_addr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      input_ready  <= 1'b0;
      rddata_ready <= 1'b0;
      wrcmd_valid  <= 1'b0;
      wrdata_valid <= 1'b0;
      output_valid <= 1'b0;
    end else begin
      input_ready <= 1'b0;
      if (output_valid && output_ready) output_valid <= 1'b0;
      case (state)
        // input_ready high means the current record is being popped this cycle.
        ST_IDLE: begin
          if (input_valid && !input_ready && !(output_valid && !output_ready)) begin
            key_q   <= in_key;
            meta_q  <= in_meta;
            user_q  <= in_user;
            addr1_q <= {in_user, in_hash[0 +: AW]};
            addr2_q <= {in_user, in_hash[32 +: AW]};
            if (is_bypass(in_meta[OPCODE_LSB +: 4])) begin
              meta_q[STATUS_LSB +: 4] <= ST_BYPASS;
              state <= ST_OUTPUT;
            end else begin
              rddata_ready <= 1'b1;
              state        <= ST_RD1;
            end
          end
        end
        ST_RD1: begin
          if (rddata_valid) begin
            ent1_q <= rddata_data;
            state  <= ST_RD2;
          end
        end
        ST_RD2: begin
          if (rddata_valid) begin
            ent2_q       <= rddata_data;
            rddata_ready <= 1'b0;
            state        <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          meta_q[STATUS_LSB +: 4]    <= dec_status;
          meta_q[0 +: VALUE_WIDTH]   <= dec_value;
          wr_addr_q                  <= dec_addr;
          wrdata_data                <= dec_entry;
          if (dec_write) begin
            wrcmd_valid  <= 1'b1;
            wrdata_valid <= 1'b1;
            state        <= ST_WRITE;
          end else begin
            state <= ST_OUTPUT;
          end
        end
        ST_WRITE: begin
          if (wrcmd_valid && wrcmd_ready)   wrcmd_valid  <= 1'b0;
          if (wrdata_valid && wrdata_ready) wrdata_valid <= 1'b0;
          if ((!wrcmd_valid || wrcmd_ready) && (!wrdata_valid || wrdata_ready))
            state <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (output_ready && !output_valid) begin
            output_data  <= {user_q, meta_q, key_q};
            output_valid <= 1'b1;
            input_ready  <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muu_ht_write.sv
// Directed-vector bench for muu_ht_write: bypass, GET/SET/DELETE outcomes,
// write back-pressure, output stall and mid-operation reset.
`timescale 1ns/1ps
module tb_muu_ht_write;

  logic         clk = 1'b0;
  logic         rst;
  logic [290:0] input_data;
  logic         input_valid;
  logic         input_ready;
  logic [191:0] rddata_data;
  logic         rddata_valid;
  logic         rddata_ready;
  logic [31:0]  wrcmd_data;
  logic         wrcmd_valid;
  logic         wrcmd_ready;
  logic [191:0] wrdata_data;
  logic         wrdata_valid;
  logic         wrdata_ready;
  logic [226:0] output_data;
  logic         output_valid;
  logic         output_ready;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  muu_ht_write dut (
    .clk          (clk),
    .rst          (rst),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .rddata_data  (rddata_data),
    .rddata_valid (rddata_valid),
    .rddata_ready (rddata_ready),
    .wrcmd_data   (wrcmd_data),
    .wrcmd_valid  (wrcmd_valid),
    .wrcmd_ready  (wrcmd_ready),
    .wrdata_data  (wrdata_data),
    .wrdata_valid (wrdata_valid),
    .wrdata_ready (wrdata_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  // Input metadata always carries a junk status and nonzero filler bits.
  function automatic logic [95:0] meta(input logic [3:0] st, input logic [3:0] op, input logic [63:0] val);
    return {st, op, 24'hA5A5A5, val};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int           lat, rdr, cmd_hs, dat_hs, ip_cnt;
  logic [31:0]  cmd_addr;
  logic [191:0] wdat;
  logic [226:0] odata;
  bit           stable, done;

  // Starts #1 after a rising edge; returns #1 after the edge that follows the output handshake.
  task automatic do_txn(input logic [290:0] rec, input bit has_resp,
                        input logic [191:0] e1, input logic [191:0] e2,
                        input int wd_hold, input int oh_hold);
    int c = 0, nresp = 0, wd_seen = 0, held = 0;
    bit popped = 0;
    logic [226:0] first = '0;
    lat = -1; rdr = 0; cmd_hs = 0; dat_hs = 0; ip_cnt = 0;
    cmd_addr = '0; wdat = '0; odata = '0; stable = 1; done = 0;
    input_data = rec; input_valid = 1'b1;
    output_ready = 1'b1; wrcmd_ready = 1'b1; wrdata_ready = (wd_hold == 0);
    rddata_valid = has_resp; rddata_data = e1;
    while (!done && c < 60) begin
      @(negedge clk);
      if (output_valid && lat < 0) begin lat = c; first = output_data; end
      if (input_ready) begin ip_cnt++; popped = 1; end
      if (rddata_ready) rdr++;
      if (rddata_valid && rddata_ready) nresp++;
      if (wrcmd_valid && wrcmd_ready) begin cmd_hs++; cmd_addr = wrcmd_data; end
      if (wrdata_valid) begin
        if (wrdata_ready) begin dat_hs++; wdat = wrdata_data; end
        wd_seen++;
      end
      if (output_valid && output_ready) begin
        done = 1; odata = output_data;
        if (output_data !== first) stable = 0;
      end
      @(posedge clk); c++; #1;
      if (popped) input_valid = 1'b0;
      rddata_valid = has_resp && (nresp < 2);
      rddata_data  = (nresp == 0) ? e1 : e2;
      wrdata_ready = (wd_seen >= wd_hold);
      if (output_valid && held < oh_hold) begin output_ready = 1'b0; held++; end
      else output_ready = 1'b1;
    end
    input_valid = 1'b0; rddata_valid = 1'b0; output_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; input_data = '0; input_valid = 1'b0; rddata_data = '0; rddata_valid = 1'b0;
    wrcmd_ready = 1'b1; wrdata_ready = 1'b1; output_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valids", {input_ready, rddata_ready, wrcmd_valid, wrdata_valid, output_valid}, 5'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // bypass, opcode 0
    do_txn({64'h0, 3'd1, meta(4'hF, 4'h0, 64'h1234), 128'h11}, 0, '0, '0, 0, 0);
    check("byp_done", done, 1);
    check("byp_out", odata, {3'd1, meta(4'h0, 4'h0, 64'h1234), 128'h11});
    check("byp_lat", lat, 2);
    check("byp_rdready", rdr, 0);
    check("byp_wrcmd", cmd_hs, 0);
    check("byp_ipulse", ip_cnt, 1);

    // bypass, unknown opcode 9
    do_txn({64'h0, 3'd0, meta(4'hF, 4'h9, 64'h3), 128'h5}, 0, '0, '0, 0, 0);
    check("op9_out", odata, {3'd0, meta(4'h0, 4'h9, 64'h3), 128'h5});
    check("op9_lat", lat, 2);

    // GET hit in slot 2
    do_txn({64'h00000005_00000006, 3'd2, meta(4'hF, 4'h1, 64'h7777), 128'hAA}, 1,
           {64'h1111, 128'h5}, {64'hBEEF, 128'hAA}, 0, 0);
    check("get_out", odata, {3'd2, meta(4'h1, 4'h1, 64'hBEEF), 128'hAA});
    check("get_lat", lat, 5);
    check("get_rdready", rdr, 2);
    check("get_wrcmd", cmd_hs, 0);

    // SET, slot1 taken by another key, slot2 empty
    do_txn({64'h00000010_00000020, 3'd3, meta(4'hF, 4'h2, 64'hDEAD), 128'hC0FFEE}, 1,
           {64'h1, 128'h77}, {64'h0, 128'h0}, 0, 0);
    check("set_out", odata, {3'd3, meta(4'h3, 4'h2, 64'hDEAD), 128'hC0FFEE});
    check("set_lat", lat, 6);
    check("set_addr", cmd_addr, 32'h000C0010);
    check("set_data", wdat, {64'hDEAD, 128'hC0FFEE});
    check("set_hs", {cmd_hs[7:0], dat_hs[7:0]}, 16'h0101);

    // SET, both slots hold other keys
    do_txn({64'h00000001_00000002, 3'd0, meta(4'hF, 4'h2, 64'h55), 128'h99}, 1,
           {64'h1, 128'h11}, {64'h2, 128'h22}, 0, 0);
    check("full_out", odata, {3'd0, meta(4'h4, 4'h2, 64'h55), 128'h99});
    check("full_lat", lat, 5);
    check("full_wrcmd", cmd_hs, 0);

    // DELETE hit in slot 1
    do_txn({64'h00000003_00000004, 3'd5, meta(4'hF, 4'h3, 64'h66), 128'h42}, 1,
           {64'h9999, 128'h42}, {64'h0, 128'h0}, 0, 0);
    check("del_out", odata, {3'd5, meta(4'h5, 4'h3, 64'h66), 128'h42});
    check("del_addr", cmd_addr, 32'h00140004);
    check("del_data", wdat, 192'h0);
    check("del_lat", lat, 6);

    // SET hit slot 1 with wrdata held off 3 cycles and output stalled 2 cycles
    do_txn({64'h00000007_00000008, 3'd1, meta(4'hF, 4'h2, 64'hABCD), 128'h3C}, 1,
           {64'h1, 128'h3C}, {64'h0, 128'h0}, 3, 2);
    check("bp_lat", lat, 9);
    check("bp_cmd_hs", cmd_hs, 1);
    check("bp_dat_hs", dat_hs, 1);
    check("bp_addr", cmd_addr, 32'h00040008);
    check("bp_data", wdat, {64'hABCD, 128'h3C});
    check("bp_stable", stable, 1);
    check("bp_out", odata, {3'd1, meta(4'h3, 4'h2, 64'hABCD), 128'h3C});

    // reset while waiting for the second response
    input_data = {64'h00000009_0000000A, 3'd4, meta(4'hF, 4'h1, 64'h1), 128'h10};
    input_valid = 1'b1; rddata_valid = 1'b1; rddata_data = {64'h5, 128'h20};
    @(posedge clk); #1;
    @(posedge clk); #1;
    rddata_valid = 1'b0;
    @(negedge clk);
    check("rd2_ready", rddata_ready, 1'b1);
    rst = 1'b1; input_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_valids", {input_ready, rddata_ready, wrcmd_valid, wrdata_valid, output_valid}, 5'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // GET miss after reset: value field untouched
    do_txn({64'h00000009_0000000A, 3'd4, meta(4'hF, 4'h1, 64'h1), 128'h10}, 1,
           {64'h5, 128'h20}, {64'h6, 128'h30}, 0, 0);
    check("post_rst_out", odata, {3'd4, meta(4'h2, 4'h1, 64'h1), 128'h10});
    check("post_rst_lat", lat, 5);
    check("post_rst_ipulse", ip_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
